// File: rtl/pwm_compare_deadtime.sv
// rtl/pwm_compare_deadtime.sv - PWM compare with shadowed thresholds and complementary dead-time outputs
// Optional feature macro: PWM_OUTPUT_POLARITY_EN (adds out_polarity input)
module pwm_compare_deadtime #(
    parameter int COUNTER_WIDTH  = 16,
    parameter int DEADTIME_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [COUNTER_WIDTH-1:0]  count_in,
    input  logic                      reload_compare,
    input  logic [COUNTER_WIDTH-1:0]  compare_low,
    input  logic [COUNTER_WIDTH-1:0]  compare_high,
    input  logic [DEADTIME_WIDTH-1:0] deadtime,
`ifdef PWM_OUTPUT_POLARITY_EN
    input  logic [1:0]                out_polarity,
`endif
    output logic                      out_a,
    output logic                      out_b,
    output logic                      in_deadtime
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        A_ON  = 3'd1,
        DT_AB = 3'd2,
        B_ON  = 3'd3,
        DT_BA = 3'd4
    } state_t;

    localparam logic [DEADTIME_WIDTH-1:0] DT_ZERO = '0;
    localparam logic [DEADTIME_WIDTH-1:0] DT_ONE  = DEADTIME_WIDTH'(1);

    logic [COUNTER_WIDTH-1:0]  low_sh_q, low_sh_d;
    logic [COUNTER_WIDTH-1:0]  high_sh_q, high_sh_d;
    logic [DEADTIME_WIDTH-1:0] dt_sh_q, dt_sh_d;
    logic [DEADTIME_WIDTH-1:0] dead_cnt_q, dead_cnt_d;
    logic                      raw_q, raw_d;
    state_t                    state_q, state_d;
    logic                      out_a_q, out_a_d;
    logic                      out_b_q, out_b_d;
    logic                      in_deadtime_q, in_deadtime_d;
    logic                      pol_a, pol_b;

`ifdef PWM_OUTPUT_POLARITY_EN
    assign pol_a = out_polarity[0];
    assign pol_b = out_polarity[1];
`else
    assign pol_a = 1'b0;
    assign pol_b = 1'b0;
`endif

    always_comb begin
        low_sh_d  = low_sh_q;
        high_sh_d = high_sh_q;
        dt_sh_d   = dt_sh_q;
        if (reload_compare) begin
            low_sh_d  = compare_low;
            high_sh_d = compare_high;
            dt_sh_d   = deadtime;
        end
        raw_d = enable && (count_in >= low_sh_q) && (count_in < high_sh_q);
    end

    // Next-state logic; the dead counter is only ever loaded on entry to a dead-time state.
    always_comb begin
        state_d    = state_q;
        dead_cnt_d = dead_cnt_q;
        if (!enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: state_d = raw_q ? A_ON : B_ON;
                A_ON: begin
                    if (!raw_q) begin
                        if (dt_sh_q == DT_ZERO) begin
                            state_d = B_ON;
                        end else begin
                            state_d    = DT_AB;
                            dead_cnt_d = dt_sh_q - DT_ONE;
                        end
                    end
                end
                DT_AB: begin
                    if (raw_q) begin
                        state_d = A_ON;
                    end else if (dead_cnt_q == DT_ZERO) begin
                        state_d = B_ON;
                    end else begin
                        dead_cnt_d = dead_cnt_q - DT_ONE;
                    end
                end
                B_ON: begin
                    if (raw_q) begin
                        if (dt_sh_q == DT_ZERO) begin
                            state_d = A_ON;
                        end else begin
                            state_d    = DT_BA;
                            dead_cnt_d = dt_sh_q - DT_ONE;
                        end
                    end
                end
                DT_BA: begin
                    if (!raw_q) begin
                        state_d = B_ON;
                    end else if (dead_cnt_q == DT_ZERO) begin
                        state_d = A_ON;
                    end else begin
                        dead_cnt_d = dead_cnt_q - DT_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        out_a_d       = (state_d == A_ON) ^ pol_a;
        out_b_d       = (state_d == B_ON) ^ pol_b;
        in_deadtime_d = (state_d == DT_AB) || (state_d == DT_BA);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            low_sh_q      <= '0;
            high_sh_q     <= '0;
            dt_sh_q       <= '0;
            dead_cnt_q    <= '0;
            raw_q         <= 1'b0;
            state_q       <= IDLE;
            out_a_q       <= pol_a;
            out_b_q       <= pol_b;
            in_deadtime_q <= 1'b0;
        end else begin
            low_sh_q      <= low_sh_d;
            high_sh_q     <= high_sh_d;
            dt_sh_q       <= dt_sh_d;
            dead_cnt_q    <= dead_cnt_d;
            raw_q         <= raw_d;
            state_q       <= state_d;
            out_a_q       <= out_a_d;
            out_b_q       <= out_b_d;
            in_deadtime_q <= in_deadtime_d;
        end
    end

    assign out_a       = out_a_q;
    assign out_b       = out_b_q;
    assign in_deadtime = in_deadtime_q;

endmodule

// File: tb/tb_pwm_compare_deadtime.sv
// tb/tb_pwm_compare_deadtime.sv - directed self-checking bench for pwm_compare_deadtime
module tb_pwm_compare_deadtime;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] count_in;
    logic        reload_compare;
    logic [15:0] compare_low;
    logic [15:0] compare_high;
    logic [7:0]  deadtime;
    logic        out_a;
    logic        out_b;
    logic        in_deadtime;

    int n_assert = 0;
    int n_fail   = 0;
    int wa, wb, wd, ov, gm;
    logic a_hist [50];
    logic b_hist [50];

    pwm_compare_deadtime #(.COUNTER_WIDTH(16), .DEADTIME_WIDTH(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .count_in       (count_in),
        .reload_compare (reload_compare),
        .compare_low    (compare_low),
        .compare_high   (compare_high),
        .deadtime       (deadtime),
`ifdef PWM_OUTPUT_POLARITY_EN
        .out_polarity   (2'b00),
`endif
        .out_a          (out_a),
        .out_b          (out_b),
        .in_deadtime    (in_deadtime)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [15:0] c, input logic rl);
        count_in       = c;
        reload_compare = rl;
        @(posedge clock);
        #1;
    endtask

    task automatic run_period(input logic do_reload);
        wa = 0; wb = 0; wd = 0; ov = 0; gm = 0;
        for (int c = 0; c < 50; c++) begin
            step(c[15:0], do_reload && (c == 0));
            a_hist[c] = out_a;
            b_hist[c] = out_b;
            wa += int'(out_a);
            wb += int'(out_b);
            wd += int'(in_deadtime);
            ov += int'(out_a & out_b);
            gm += int'(in_deadtime != (!out_a && !out_b));
        end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; count_in = '0; reload_compare = 1'b0;
        compare_low = '0; compare_high = '0; deadtime = '0;
        #3;
        check("reset_out_a", int'(out_a), 0);
        check("reset_out_b", int'(out_b), 0);
        check("reset_in_dt", int'(in_deadtime), 0);
        @(posedge clock); @(posedge clock); #3;
        reset = 1'b1;

        // 10/20, dead time 0
        compare_low = 16'd10; compare_high = 16'd20; deadtime = 8'd0; enable = 1'b1;
        run_period(1'b1);
        run_period(1'b1);
        check("d0_a10", int'(a_hist[10]), 0);
        check("d0_a11", int'(a_hist[11]), 1);
        check("d0_b11", int'(b_hist[11]), 0);
        check("d0_a20", int'(a_hist[20]), 1);
        check("d0_a21", int'(a_hist[21]), 0);
        check("d0_b21", int'(b_hist[21]), 1);
        check("d0_width_a", wa, 10);
        check("d0_width_b", wb, 40);
        check("d0_overlap", ov, 0);

        // 10/20, dead time 3
        deadtime = 8'd3;
        run_period(1'b1);
        run_period(1'b1);
        check("d3_a13", int'(a_hist[13]), 0);
        check("d3_a14", int'(a_hist[14]), 1);
        check("d3_a20", int'(a_hist[20]), 1);
        check("d3_a21", int'(a_hist[21]), 0);
        check("d3_b23", int'(b_hist[23]), 0);
        check("d3_b24", int'(b_hist[24]), 1);
        check("d3_width_a", wa, 7);
        check("d3_width_b", wb, 37);
        check("d3_width_dt", wd, 6);
        check("d3_overlap", ov, 0);
        check("d3_dt_gaps", gm, 0);

        // shadow hold: new values ignored until reload strobe
        compare_high = 16'd30; deadtime = 8'd0;
        run_period(1'b0);
        check("hold_width_a", wa, 7);
        check("hold_width_dt", wd, 6);
        run_period(1'b1);
        check("reload_width_a", wa, 20);
        check("reload_width_b", wb, 30);
        check("reload_a30", int'(a_hist[30]), 1);
        check("reload_a31", int'(a_hist[31]), 0);
        check("reload_overlap", ov, 0);

        // 2-cycle raw dropout shorter than dead time 5
        compare_low = 16'd10; compare_high = 16'd40; deadtime = 8'd5;
        step(16'd0, 1'b1);
        for (int c = 1; c <= 20; c++) step(c[15:0], 1'b0);
        check("pulse_a_on", int'(out_a), 1);
        step(16'd45, 1'b0);
        check("pulse_a_still", int'(out_a), 1);
        step(16'd46, 1'b0);
        check("pulse_a_drop", int'(out_a), 0);
        check("pulse_b_off1", int'(out_b), 0);
        check("pulse_in_dt", int'(in_deadtime), 1);
        step(16'd21, 1'b0);
        check("pulse_b_off2", int'(out_b), 0);
        step(16'd22, 1'b0);
        check("pulse_a_back", int'(out_a), 1);
        check("pulse_b_off3", int'(out_b), 0);

        // enable low, then inverted thresholds
        enable = 1'b0;
        step(16'd23, 1'b0);
        check("dis_a", int'(out_a), 0);
        check("dis_b", int'(out_b), 0);
        compare_low = 16'd30; compare_high = 16'd5; deadtime = 8'd0; enable = 1'b1;
        run_period(1'b1);
        run_period(1'b1);
        check("inv_width_a", wa, 0);
        check("inv_width_b", wb, 50);

        // asynchronous reset while out_a is high
        compare_low = 16'd10; compare_high = 16'd20; deadtime = 8'd0;
        run_period(1'b1);
        for (int c = 0; c <= 14; c++) step(c[15:0], c == 0);
        check("rst1_pre_a", int'(out_a), 1);
        #2 reset = 1'b0;
        #1;
        check("rst1_async_a", int'(out_a), 0);
        check("rst1_async_b", int'(out_b), 0);
        #3 reset = 1'b1;
        step(16'd15, 1'b0);
        check("rst1_idle_a", int'(out_a), 0);
        check("rst1_idle_b", int'(out_b), 1);
        for (int c = 16; c <= 20; c++) step(c[15:0], 1'b0);
        check("rst1_shadow_cleared", int'(out_a), 0);

        // asynchronous reset during DT_AB
        deadtime = 8'd3;
        for (int c = 0; c <= 21; c++) step(c[15:0], c == 0);
        check("rst2_pre_dt", int'(in_deadtime), 1);
        check("rst2_pre_a", int'(out_a), 0);
        #2 reset = 1'b0;
        #1;
        check("rst2_async_dt", int'(in_deadtime), 0);
        check("rst2_async_b", int'(out_b), 0);
        #3 reset = 1'b1;
        step(16'd22, 1'b0);
        check("rst2_idle_b", int'(out_b), 1);
        check("rst2_idle_dt", int'(in_deadtime), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
